phv_merger: RTL and testbench
=============================

PHV_MERGER -- requirements
Module: phv_merger

Parameters
REQ-001 SHALL have parameter STAGE_ID, default 0, pipeline stage index (informational only).
REQ-002 SHALL have parameter PHV_LEN, default 48*8+32*8+16*8+256 (=1024), PHV width.
REQ-003 SHALL have parameter ACT_LEN, default 25, width of one action slot.
REQ-004 SHALL have parameters width_2B=16, width_4B=32, width_6B=48, container widths.

Interface
REQ-005 SHALL have: clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have: alu_in_valid  input  1  ALU result beat valid.
REQ-008 SHALL have: alu_out_6B  input  384  eight 6B results, container i at [(i+1)*48-1 -: 48].
REQ-009 SHALL have: alu_out_4B  input  256  eight 4B results, same indexing.
REQ-010 SHALL have: alu_out_2B  input  128  eight 2B results, same indexing.
REQ-011 SHALL have: phv_orig  input  PHV_LEN  original PHV aligned with the ALU beat.
REQ-012 SHALL have: action_in  input  ACT_LEN*25  actions aligned with the ALU beat; slot k at [ACT_LEN*(k+1)-1 -: ACT_LEN].
REQ-013 SHALL have: ready_out  output  1  merger can accept a beat.
REQ-014 SHALL have: phv_out  output  PHV_LEN  reassembled PHV.
REQ-015 SHALL have: phv_out_valid  output  1  phv_out valid.
REQ-016 SHALL have: ready_in  input  1  downstream accepts phv_out.
REQ-017 SHALL have: pkt_in_cnt, pkt_out_cnt  output  32 each  accepted / delivered beat counters.

Function
REQ-018 SHALL accept a beat on a rising edge iff alu_in_valid && ready_out; deliver on a rising edge iff phv_out_valid && ready_in.
REQ-019 SHALL order phv_out MSB→LSB: 6B c7..c0, 4B c7..c0, 2B c7..c0, 256-bit remain; remain = phv_orig[255:0] unmodified.
REQ-020 SHALL map action slots: 6B ci ← slot 17+i, 4B ci ← slot 9+i, 2B ci ← slot 1+i; slot 0 ignored; opcode = slot[24:21].
REQ-021 SHALL take container ci from the ALU result when opcode ∈ {0001,0010,1001,1010,1110}, or for 4B additionally ∈ {0111,1000,1011}; otherwise from the matching phv_orig container.
REQ-022 SHALL buffer merged beats in a 2-entry in-order FIFO; FSM states EMPTY, ONE, TWO by occupancy.
REQ-023 SHALL drive ready_out = 1 in EMPTY and ONE, 0 in TWO, decoded from the state register only (no combinational path from ready_in).
REQ-024 SHALL transition: EMPTY+push→ONE; ONE+push only→TWO; ONE+pop only→EMPTY; ONE+push+pop→ONE; TWO+pop→ONE; otherwise hold.
REQ-025 SHALL present the head entry on phv_out with phv_out_valid = (state≠EMPTY); minimum latency accept edge N → phv_out_valid at N+1.
REQ-026 SHALL hold phv_out stable while phv_out_valid && !ready_in.
REQ-027 SHALL, on ONE with simultaneous push and pop, present the newly pushed beat on the following cycle with no bubble.
REQ-028 SHALL ignore alu_in_valid while ready_out=0; the beat is not captured and not counted.
REQ-029 SHALL increment pkt_in_cnt per push and pkt_out_cnt per pop, modulo 2^32 (0xFFFFFFFF → 0).
REQ-030 SHALL keep phv_out contents undefined-free: buffer registers written only on push.

Reset
REQ-031 SHALL, while rst=1 at a rising edge: state→EMPTY, phv_out_valid=0, ready_out=1, phv_out=0, both counters=0.
REQ-032 SHALL discard buffered beats when rst asserts mid-operation; no delivery occurs in the reset cycle.
REQ-033 SHALL accept a beat on the first rising edge after rst deasserts.

Verification
REQ-034 SHALL test pass-through: all opcodes 0000, phv_orig=pattern P, ALU results all 0xFF.. -> phv_out==P one cycle after accept.
REQ-035 SHALL test merge: 6B slot 24 opcode 0001, 4B slot 9 opcode 1011, 2B slot 1 opcode 1110, ALU 6B c7=0x123456789ABC, 4B c0=0xDEADBEEF, 2B c0=0x00AA -> exactly those three containers replaced, remain bits unchanged.
REQ-036 SHALL test backpressure: ready_in=0, push 3 beats -> ready_out low after 2 accepted, third held; ready_in=1 -> beats 1,2 out in order, then third accepted, pkt_in_cnt=pkt_out_cnt=3.
REQ-037 SHALL test streaming: ready_in=1, alu_in_valid=1 for 10 cycles -> 10 back-to-back outputs, ready_out never low.
REQ-038 SHALL test reset mid-operation: state TWO, rst pulsed 1 cycle -> phv_out_valid=0, ready_out=1, counters=0 next cycle.
REQ-039 SHALL test counter wrap: pkt_out_cnt forced to 0xFFFFFFFF, one delivery -> 0.

Source files
------------

// File: rtl/phv_merger.sv
// PHV merger: selects each container from the ALU result or the original PHV by
// its action opcode, then queues the reassembled PHV in a 2-entry in-order FIFO.
module phv_merger #(
   parameter int STAGE_ID = 0,
   parameter int PHV_LEN  = 48*8+32*8+16*8+256,
   parameter int ACT_LEN  = 25,
   parameter int width_2B = 16,
   parameter int width_4B = 32,
   parameter int width_6B = 48
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    alu_in_valid,
   input  logic [width_6B*8-1:0]   alu_out_6B,
   input  logic [width_4B*8-1:0]   alu_out_4B,
   input  logic [width_2B*8-1:0]   alu_out_2B,
   input  logic [PHV_LEN-1:0]      phv_orig,
   input  logic [ACT_LEN*25-1:0]   action_in,
   output logic                    ready_out,
   output logic [PHV_LEN-1:0]      phv_out,
   output logic                    phv_out_valid,
   input  logic                    ready_in,
   output logic [31:0]             pkt_in_cnt,
   output logic [31:0]             pkt_out_cnt
);

   localparam int REM_W   = 256;
   localparam int BASE_2B = REM_W;
   localparam int BASE_4B = BASE_2B + 8*width_2B;
   localparam int BASE_6B = BASE_4B + 8*width_4B;

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [PHV_LEN-1:0]   r_mem [2];
   logic                 r_wr_ptr;
   logic                 r_rd_ptr;
   logic [31:0]          r_pkt_in_cnt;
   logic [31:0]          r_pkt_out_cnt;
   logic [PHV_LEN-1:0]   w_merged;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_unused;

   // Opcodes that take the ALU result; 4B containers accept three extra opcodes.
   function automatic logic use_alu(input logic [3:0] op, input logic is_4b);
      logic sel;
      sel = (op == 4'b0001) || (op == 4'b0010) || (op == 4'b1001) ||
            (op == 4'b1010) || (op == 4'b1110);
      if (is_4b)
         sel = sel || (op == 4'b0111) || (op == 4'b1000) || (op == 4'b1011);
      return sel;
   endfunction

   always_comb begin
      w_merged = phv_orig;
      for (int i = 0; i < 8; i++) begin
         if (use_alu(action_in[ACT_LEN*(18+i)-1 -: 4], 1'b0))
            w_merged[BASE_6B+(i+1)*width_6B-1 -: width_6B] = alu_out_6B[(i+1)*width_6B-1 -: width_6B];
         if (use_alu(action_in[ACT_LEN*(10+i)-1 -: 4], 1'b1))
            w_merged[BASE_4B+(i+1)*width_4B-1 -: width_4B] = alu_out_4B[(i+1)*width_4B-1 -: width_4B];
         if (use_alu(action_in[ACT_LEN*(2+i)-1 -: 4], 1'b0))
            w_merged[BASE_2B+(i+1)*width_2B-1 -: width_2B] = alu_out_2B[(i+1)*width_2B-1 -: width_2B];
      end
   end

   assign ready_out     = (r_state != TWO);
   assign phv_out_valid = (r_state != EMPTY);
   assign w_push        = alu_in_valid && ready_out;
   assign w_pop         = phv_out_valid && ready_in;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         EMPTY: if (w_push) w_state_nxt = ONE;
         ONE: begin
            if (w_push && !w_pop)      w_state_nxt = TWO;
            else if (!w_push && w_pop) w_state_nxt = EMPTY;
         end
         TWO:   if (w_pop) w_state_nxt = ONE;
         default: w_state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= EMPTY;
         r_wr_ptr      <= 1'b0;
         r_rd_ptr      <= 1'b0;
         r_pkt_in_cnt  <= '0;
         r_pkt_out_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_push) begin
            r_wr_ptr     <= ~r_wr_ptr;
            r_pkt_in_cnt <= r_pkt_in_cnt + 32'd1;
         end
         if (w_pop) begin
            r_rd_ptr      <= ~r_rd_ptr;
            r_pkt_out_cnt <= r_pkt_out_cnt + 32'd1;
         end
      end
   end

   // Storage is only ever written on a push; the output mux forces zero when empty.
   always_ff @(posedge clk) begin
      if (w_push && !rst)
         r_mem[r_wr_ptr] <= w_merged;
   end

   assign phv_out     = phv_out_valid ? r_mem[r_rd_ptr] : '0;
   assign pkt_in_cnt  = r_pkt_in_cnt;
   assign pkt_out_cnt = r_pkt_out_cnt;
   assign w_unused    = ^{action_in, 32'(STAGE_ID)};

endmodule

// File: tb/tb_phv_merger.sv
// Bench for phv_merger: table of merge vectors plus backpressure, streaming,
// reset and counter-wrap sequences, all checked through an output scoreboard.
module tb_phv_merger;

   typedef logic [1023:0] phv_t;
   typedef logic [624:0]  act_t;
   typedef struct {
      phv_t         orig;
      act_t         act;
      logic [383:0] a6;
      logic [255:0] a4;
      logic [127:0] a2;
      phv_t         exp;
   } vec_t;

   logic         clk = 0;
   logic         rst;
   logic         alu_in_valid;
   logic [383:0] alu_out_6B;
   logic [255:0] alu_out_4B;
   logic [127:0] alu_out_2B;
   phv_t         phv_orig;
   act_t         action_in;
   logic         ready_out;
   phv_t         phv_out;
   logic         phv_out_valid;
   logic         ready_in;
   logic [31:0]  pkt_in_cnt;
   logic [31:0]  pkt_out_cnt;

   int   total = 0;
   int   bad = 0;
   int   n_out = 0;
   int   cyc = 0;
   bit   stream_on = 0;
   int   stream_low = 0;
   int   stream_gap = 0;
   phv_t cur_exp;
   phv_t sb[$];
   vec_t vt[6];

   phv_merger dut (
      .clk(clk), .rst(rst), .alu_in_valid(alu_in_valid),
      .alu_out_6B(alu_out_6B), .alu_out_4B(alu_out_4B), .alu_out_2B(alu_out_2B),
      .phv_orig(phv_orig), .action_in(action_in), .ready_out(ready_out),
      .phv_out(phv_out), .phv_out_valid(phv_out_valid), .ready_in(ready_in),
      .pkt_in_cnt(pkt_in_cnt), .pkt_out_cnt(pkt_out_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic chkphv(input string name, input phv_t act, input phv_t exp);
      bit shown;
      total++;
      if (act !== exp) begin
         bad++;
         shown = 0;
         for (int k = 15; k >= 0; k--)
            if (!shown && act[k*64 +: 64] !== exp[k*64 +: 64]) begin
               $display("FAIL %s chunk%0d got=%h want=%h", name, k, act[k*64 +: 64], exp[k*64 +: 64]);
               shown = 1;
            end
      end
   endtask

   // Scoreboard: push on accept, pop/compare on delivery, flush on reset.
   always @(negedge clk) begin
      if (rst) sb.delete();
      else begin
         if (phv_out_valid && ready_in) begin
            n_out++;
            if (sb.size() == 0) begin
               total++; bad++;
               $display("FAIL sb_underflow got=%h want=none", phv_out[63:0]);
            end else chkphv("phv_out", phv_out, sb.pop_front());
         end
         if (alu_in_valid && ready_out) sb.push_back(cur_exp);
         if (stream_on && !ready_out) stream_low++;
         if (stream_on && !phv_out_valid) stream_gap++;
      end
   end

   function automatic phv_t rnd();
      phv_t r;
      for (int k = 0; k < 32; k++) r[k*32 +: 32] = $urandom();
      return r;
   endfunction

   function automatic act_t rnd_act_noop();
      act_t a;
      for (int k = 0; k < 20; k++) a = {a[592:0], 32'($urandom())};
      for (int s = 0; s < 25; s++) a[25*s+24 -: 4] = 4'b0000;
      return a;
   endfunction

   function automatic act_t set_op(input act_t a, input int slot, input logic [3:0] op);
      a[25*slot+24 -: 4] = op;
      return a;
   endfunction

   task automatic set_beat(input vec_t v);
      phv_orig = v.orig; action_in = v.act;
      alu_out_6B = v.a6; alu_out_4B = v.a4; alu_out_2B = v.a2;
      cur_exp = v.exp;
      alu_in_valid = 1;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic wait_accept();
      bit acc = 0;
      for (int k = 0; k < 40 && !acc; k++) begin
         @(negedge clk);
         if (ready_out) acc = 1;
         @(posedge clk); #1;
      end
      if (!acc) begin
         total++; bad++;
         $display("FAIL accept_timeout got=0 want=1");
      end
   endtask

   task automatic drain();
      bit done = 0;
      for (int k = 0; k < 40 && !done; k++) begin
         @(posedge clk); #1;
         if (sb.size() == 0 && !phv_out_valid) done = 1;
      end
      if (!done) begin
         total++; bad++;
         $display("FAIL drain_timeout got=%0d want=0", sb.size());
      end
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1; rst = 1;
      @(posedge clk); #1; rst = 0;
   endtask

   initial begin
      phv_t t;
      int base_in, base_out, base_n, start;

      // Pass-through: opcodes all zero, ALU all ones.
      vt[0].orig = rnd(); vt[0].act = rnd_act_noop();
      vt[0].a6 = '1; vt[0].a4 = '1; vt[0].a2 = '1;
      vt[0].exp = vt[0].orig;
      // Three-container merge with fixed result values.
      vt[1].orig = rnd(); vt[1].act = rnd_act_noop();
      vt[1].act = set_op(vt[1].act, 24, 4'b0001);
      vt[1].act = set_op(vt[1].act, 9, 4'b1011);
      vt[1].act = set_op(vt[1].act, 1, 4'b1110);
      t = rnd(); vt[1].a6 = t[383:0]; vt[1].a4 = t[1023:768]; vt[1].a2 = t[511:384];
      vt[1].a6[383:336] = 48'h123456789ABC; vt[1].a4[31:0] = 32'hDEADBEEF; vt[1].a2[15:0] = 16'h00AA;
      vt[1].exp = vt[1].orig;
      vt[1].exp[1023:976] = 48'h123456789ABC;
      vt[1].exp[415:384]  = 32'hDEADBEEF;
      vt[1].exp[271:256]  = 16'h00AA;
      // 0111 counts only for 4B; 1001 for 2B.
      vt[2].orig = rnd(); vt[2].act = rnd_act_noop();
      vt[2].act = set_op(vt[2].act, 12, 4'b0111);
      vt[2].act = set_op(vt[2].act, 17, 4'b0111);
      vt[2].act = set_op(vt[2].act, 6, 4'b1001);
      t = rnd(); vt[2].a6 = t[383:0]; vt[2].a4 = t[1023:768]; vt[2].a2 = t[511:384];
      vt[2].exp = vt[2].orig;
      vt[2].exp[511:480] = vt[2].a4[127:96];
      vt[2].exp[351:336] = vt[2].a2[95:80];
      // Every container from the ALU.
      vt[3].orig = rnd(); vt[3].act = rnd_act_noop();
      for (int s = 1; s < 25; s++) vt[3].act = set_op(vt[3].act, s, 4'b1010);
      t = rnd(); vt[3].a6 = t[383:0]; vt[3].a4 = t[1023:768]; vt[3].a2 = t[511:384];
      vt[3].exp = {vt[3].a6, vt[3].a4, vt[3].a2, vt[3].orig[255:0]};
      // Slot 0 is ignored.
      vt[4].orig = rnd(); vt[4].act = rnd_act_noop();
      vt[4].act = set_op(vt[4].act, 0, 4'b0001);
      t = rnd(); vt[4].a6 = t[383:0]; vt[4].a4 = t[1023:768]; vt[4].a2 = t[511:384];
      vt[4].exp = vt[4].orig;
      // 1000 only for 4B, 1110 for 6B, 0011 never.
      vt[5].orig = rnd(); vt[5].act = rnd_act_noop();
      vt[5].act = set_op(vt[5].act, 16, 4'b1000);
      vt[5].act = set_op(vt[5].act, 8, 4'b1000);
      vt[5].act = set_op(vt[5].act, 20, 4'b1110);
      vt[5].act = set_op(vt[5].act, 21, 4'b0011);
      t = rnd(); vt[5].a6 = t[383:0]; vt[5].a4 = t[1023:768]; vt[5].a2 = t[511:384];
      vt[5].exp = vt[5].orig;
      vt[5].exp[639:608] = vt[5].a4[255:224];
      vt[5].exp[831:784] = vt[5].a6[191:144];

      rst = 1; alu_in_valid = 0; ready_in = 1;
      phv_orig = '0; action_in = '0; alu_out_6B = '0; alu_out_4B = '0; alu_out_2B = '0;
      cur_exp = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 64'(phv_out_valid), 64'd0);
      chk("rst_ready", 64'(ready_out), 64'd1);
      chk("rst_in_cnt", 64'(pkt_in_cnt), 64'd0);
      chk("rst_out_cnt", 64'(pkt_out_cnt), 64'd0);
      chkphv("rst_phv", phv_out, '0);
      rst = 0;

      for (int i = 0; i < 6; i++) begin
         set_beat(vt[i]);
         wait_accept();
         chk("latency_valid", 64'(phv_out_valid), 64'd1);
         alu_in_valid = 0;
         drain();
      end
      chk("table_in_cnt", 64'(pkt_in_cnt), 64'd6);
      chk("table_out_cnt", 64'(pkt_out_cnt), 64'd6);

      // Backpressure: two accepted, third held until downstream drains.
      pulse_reset();
      ready_in = 0;
      set_beat(vt[0]); wait_accept();
      set_beat(vt[1]); wait_accept();
      chk("bp_ready_full", 64'(ready_out), 64'd0);
      set_beat(vt[2]);
      repeat (3) begin
         @(negedge clk);
         chk("bp_ready_held", 64'(ready_out), 64'd0);
         chkphv("bp_hold", phv_out, vt[0].exp);
      end
      chk("bp_in_cnt_2", 64'(pkt_in_cnt), 64'd2);
      @(posedge clk); #1; ready_in = 1;
      wait_accept();
      alu_in_valid = 0;
      drain();
      chk("bp_in_cnt", 64'(pkt_in_cnt), 64'd3);
      chk("bp_out_cnt", 64'(pkt_out_cnt), 64'd3);

      // Streaming: ten back-to-back beats.
      base_in = int'(pkt_in_cnt); base_out = int'(pkt_out_cnt); base_n = n_out;
      start = cyc;
      for (int i = 0; i < 10; i++) begin
         set_beat(vt[i % 6]);
         wait_accept();
         if (i == 0) stream_on = 1;
      end
      stream_on = 0;
      chk("stream_cycles", 64'(cyc - start), 64'd10);
      alu_in_valid = 0;
      drain();
      chk("stream_ready_low", 64'(stream_low), 64'd0);
      chk("stream_gaps", 64'(stream_gap), 64'd0);
      chk("stream_outs", 64'(n_out - base_n), 64'd10);
      chk("stream_in_cnt", 64'(int'(pkt_in_cnt) - base_in), 64'd10);
      chk("stream_out_cnt", 64'(int'(pkt_out_cnt) - base_out), 64'd10);

      // Reset while full, then accept on the first edge after release.
      ready_in = 0;
      set_beat(vt[2]); wait_accept();
      set_beat(vt[3]); wait_accept();
      alu_in_valid = 0;
      chk("mid_full", 64'(ready_out), 64'd0);
      rst = 1; ready_in = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("mid_valid", 64'(phv_out_valid), 64'd0);
      chk("mid_ready", 64'(ready_out), 64'd1);
      chk("mid_in_cnt", 64'(pkt_in_cnt), 64'd0);
      chk("mid_out_cnt", 64'(pkt_out_cnt), 64'd0);
      chkphv("mid_phv", phv_out, '0);
      set_beat(vt[5]);
      @(posedge clk); #1;
      alu_in_valid = 0;
      chk("post_rst_accept", 64'(pkt_in_cnt), 64'd1);
      chk("post_rst_valid", 64'(phv_out_valid), 64'd1);
      drain();

      // Delivery counter wrap.
      set_beat(vt[4]);
      wait_accept();
      alu_in_valid = 0;
      force dut.r_pkt_out_cnt = 32'hFFFFFFFF;
      #1;
      release dut.r_pkt_out_cnt;
      chk("wrap_preset", 64'(pkt_out_cnt), 64'hFFFFFFFF);
      @(posedge clk); #1;
      chk("wrap_zero", 64'(pkt_out_cnt), 64'd0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
